// File: rtl/ctlb_miss_ctrl.sv
// ctlb_miss_ctrl: code-TLB miss and flush sequencer for the fetch unit.
// A fetch miss stalls fetch, issues a page-walk request, and installs the
// returned translation through the ctlb write port. A walk fault is reported
// on fault_vld. A flush request sweeps every ctlb set with an invalidate strobe.
// Reset starts a full flush.
// Optional feature: define CTLB_MISS_CTRL_TIMEOUT_EN to abort a walk that has
// not completed within TMO cycles. The abort is reported as a fault.

`ifndef ctlbData_width
`define ctlbData_width 64
`endif

module ctlb_miss_ctrl #(
  parameter int unsigned OUTDATA_W = `ctlbData_width,
  parameter int unsigned IP_W      = 65,
  parameter int unsigned SETS      = 64,
  parameter int unsigned TMO       = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_vld,
  input  logic [IP_W-1:0]      fetch_addr,
  input  logic                 fetch_nat,
  input  logic                 tlb_hit,
  output logic                 fetch_stall,
  output logic                 walk_req,
  output logic [IP_W-1:0]      walk_addr,
  input  logic                 walk_ack,
  input  logic                 walk_rsp_vld,
  input  logic [OUTDATA_W-1:0] walk_rsp_data,
  input  logic                 walk_rsp_flt,
  output logic                 tlb_wen,
  output logic [OUTDATA_W-1:0] tlb_wdata,
  output logic [IP_W-1:0]      tlb_waddr,
  output logic                 tlb_wnat,
  output logic                 tlb_inval,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 fault_vld,
  output logic [IP_W-1:0]      fault_addr
);

  localparam int unsigned IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_FLUSH
  } state_t;

  state_t                state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  flush_pend, flush_pend_nx;
  logic [IP_W-1:0]       miss_addr;
  logic                  miss_nat;
  logic [OUTDATA_W-1:0]  fill_data;
  logic                  fault_q;
  logic [IP_W-1:0]       fault_addr_q;
  logic                  take_miss;
  logic                  rsp_ok;
  logic                  rsp_flt;
  logic                  timeout;
  logic                  flush_want;
  logic [IP_W-1:0]       flush_addr;

  // Response qualifiers.
  // A response arriving outside WAIT is dropped.
  always_comb begin
    rsp_ok     = (state == S_WAIT) && walk_rsp_vld && !walk_rsp_flt;
    rsp_flt    = (state == S_WAIT) && walk_rsp_vld && walk_rsp_flt;
    flush_want = flush_req || flush_pend;
    take_miss  = (state == S_IDLE) && fetch_vld && !tlb_hit && !flush_want;
    flush_addr = IP_W'({idx, 13'b0});
  end

`ifdef CTLB_MISS_CTRL_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Walk age counter.
  // It clears whenever no walk is outstanding.
  always_ff @(posedge clk) begin
    if (rst || !((state == S_REQ) || (state == S_WAIT))) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Timeout fires on the TMO-th cycle of the walk.
  // A response seen in that same cycle takes precedence over the timeout.
  always_comb begin
    timeout = ((state == S_REQ) || ((state == S_WAIT) && !walk_rsp_vld)) &&
              (tmo_cnt == 8'(TMO - 1));
  end
`else
  // Without the timeout feature, a walk waits indefinitely.
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Next-state logic, flush index, and pending-flush bookkeeping.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    flush_pend_nx = flush_pend;
    case (state)
      S_IDLE: begin
        if (flush_want) begin
          state_nx      = S_FLUSH;
          idx_nx        = '0;
          flush_pend_nx = 1'b0;
        end else if (fetch_vld && !tlb_hit) begin
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_req) begin
          flush_pend_nx = 1'b1;
        end
        if (timeout) begin
          state_nx = S_IDLE;
        end else if (walk_ack) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_req) begin
          flush_pend_nx = 1'b1;
        end
        if (rsp_ok) begin
          state_nx = S_FILL;
        end else if (rsp_flt) begin
          // A fault ends the walk.
          // Go straight to FLUSH if one is owed, so fetch stays stalled.
          if (flush_want) begin
            state_nx      = S_FLUSH;
            idx_nx        = '0;
            flush_pend_nx = 1'b0;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      S_FILL: begin
        // Chain into the owed flush without an IDLE gap.
        if (flush_want) begin
          state_nx      = S_FLUSH;
          idx_nx        = '0;
          flush_pend_nx = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FLUSH: begin
        flush_pend_nx = 1'b0;
        if (flush_req) begin
          idx_nx = '0;
        end else if (idx == IDX_LAST) begin
          state_nx = S_IDLE;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  // Reset enters a full flush at set 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FLUSH;
      idx        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      flush_pend <= flush_pend_nx;
    end
  end

  // Capture the miss context, the fill data, and the one-cycle fault report.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr    <= '0;
      miss_nat     <= 1'b0;
      fill_data    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      if (take_miss) begin
        miss_addr <= fetch_addr;
        miss_nat  <= fetch_nat;
      end
      if (rsp_ok) begin
        fill_data <= walk_rsp_data;
      end
      fault_q <= rsp_flt || timeout;
      if (rsp_flt || timeout) begin
        fault_addr_q <= miss_addr;
      end
    end
  end

  // Outputs decoded from state and the captured registers.
  always_comb begin
    fetch_stall = (state != S_IDLE);
    walk_req    = (state == S_REQ);
    walk_addr   = miss_addr;
    tlb_wen     = (state == S_FILL);
    tlb_wdata   = fill_data;
    tlb_wnat    = (state == S_FILL) && miss_nat;
    tlb_inval   = (state == S_FLUSH);
    flush_busy  = (state == S_FLUSH);
    fault_vld   = fault_q;
    fault_addr  = fault_addr_q;
    tlb_waddr   = '0;
    if (state == S_FILL) begin
      tlb_waddr = miss_addr;
    end else if (state == S_FLUSH) begin
      tlb_waddr = flush_addr;
    end
  end

endmodule

// File: tb/tb_ctlb_miss_ctrl.sv
// Directed testbench for ctlb_miss_ctrl.
// Covers the reset flush, a fill, a faulting walk, a flush during a walk,
// flush/miss contention, a flush restart, and reset during a walk.
module tb_ctlb_miss_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 65;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_vld;
  logic [AW-1:0] fetch_addr;
  logic          fetch_nat;
  logic          tlb_hit;
  logic          fetch_stall;
  logic          walk_req;
  logic [AW-1:0] walk_addr;
  logic          walk_ack;
  logic          walk_rsp_vld;
  logic [DW-1:0] walk_rsp_data;
  logic          walk_rsp_flt;
  logic          tlb_wen;
  logic [DW-1:0] tlb_wdata;
  logic [AW-1:0] tlb_waddr;
  logic          tlb_wnat;
  logic          tlb_inval;
  logic          flush_req;
  logic          flush_busy;
  logic          fault_vld;
  logic [AW-1:0] fault_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int wen_cnt = 0;

  ctlb_miss_ctrl #(
    .OUTDATA_W(DW),
    .IP_W(AW),
    .SETS(64),
    .TMO(255)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_vld(fetch_vld), .fetch_addr(fetch_addr), .fetch_nat(fetch_nat),
    .tlb_hit(tlb_hit), .fetch_stall(fetch_stall),
    .walk_req(walk_req), .walk_addr(walk_addr), .walk_ack(walk_ack),
    .walk_rsp_vld(walk_rsp_vld), .walk_rsp_data(walk_rsp_data),
    .walk_rsp_flt(walk_rsp_flt),
    .tlb_wen(tlb_wen), .tlb_wdata(tlb_wdata), .tlb_waddr(tlb_waddr),
    .tlb_wnat(tlb_wnat), .tlb_inval(tlb_inval),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .fault_vld(fault_vld), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tlb_wen === 1'b1) wen_cnt <= wen_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts the cycles that flush_busy stays high, starting from the current sample.
  task automatic run_flush(output int n, output bit stall_ok, output bit req_seen);
    n = 0; stall_ok = 1'b1; req_seen = 1'b0;
    while (flush_busy === 1'b1 && n < 300) begin
      if (fetch_stall !== 1'b1) stall_ok = 1'b0;
      if (walk_req !== 1'b0) req_seen = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    logic [AW-1:0] exp_a;
    rst = 1'b1; fetch_vld = 0; fetch_addr = '0; fetch_nat = 0; tlb_hit = 0;
    walk_ack = 0; walk_rsp_vld = 0; walk_rsp_data = '0; walk_rsp_flt = 0; flush_req = 0;
    tick(); tick();
    n_chk++; if (flush_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b exp 1", flush_busy); end
    n_chk++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b exp 1", fetch_stall); end
    n_chk++; if (walk_req !== 1'b0) begin n_fail++; $display("FAIL rst_walk_req: got %b exp 0", walk_req); end
    n_chk++; if (tlb_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b exp 0", tlb_wen); end
    n_chk++; if (fault_vld !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b exp 0", fault_vld); end
    n_chk++; if (walk_addr !== '0) begin n_fail++; $display("FAIL rst_walk_addr: got %h exp 0", walk_addr); end
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_a = AW'(i) << 13;
      n_chk++; if (tlb_inval !== 1'b1 || flush_busy !== 1'b1) begin
        n_fail++; $display("FAIL rst_sweep_strobe[%0d]: inval=%b busy=%b exp 1/1", i, tlb_inval, flush_busy);
      end
      n_chk++; if (tlb_waddr !== exp_a) begin
        n_fail++; $display("FAIL rst_sweep_addr[%0d]: got %h exp %h", i, tlb_waddr, exp_a);
      end
      tick();
    end
    n_chk++; if (flush_busy !== 1'b0 || fetch_stall !== 1'b0 || tlb_inval !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: busy=%b stall=%b inval=%b exp 0/0/0", flush_busy, fetch_stall, tlb_inval);
    end
  endtask

  task automatic test_miss_fill;
    logic [AW-1:0] a;
    int w0;
    a = 65'h1_2345_6000;
    // A hit must not start a walk.
    fetch_vld = 1; tlb_hit = 1; fetch_addr = 65'h77_7000;
    tick();
    n_chk++; if (fetch_stall !== 1'b0 || walk_req !== 1'b0) begin
      n_fail++; $display("FAIL hit_ignored: stall=%b req=%b exp 0/0", fetch_stall, walk_req);
    end
    tlb_hit = 0; fetch_addr = a; fetch_nat = 1;
    tick();
    // While in REQ, a second miss and a stray response must both be ignored.
    fetch_addr = 65'h999_9000; fetch_nat = 0;
    walk_rsp_vld = 1; walk_rsp_data = 64'h555;
    n_chk++; if (walk_req !== 1'b1 || walk_addr !== a || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL miss_req: req=%b addr=%h stall=%b exp 1/%h/1", walk_req, walk_addr, fetch_stall, a);
    end
    tick();
    fetch_vld = 0; walk_rsp_vld = 0;
    n_chk++; if (walk_req !== 1'b1 || walk_addr !== a || tlb_wen !== 1'b0) begin
      n_fail++; $display("FAIL miss_req_hold: req=%b addr=%h wen=%b exp 1/%h/0", walk_req, walk_addr, tlb_wen, a);
    end
    walk_ack = 1;
    tick();
    walk_ack = 0;
    n_chk++; if (walk_req !== 1'b0 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL miss_wait: req=%b stall=%b exp 0/1", walk_req, fetch_stall);
    end
    tick(); tick();
    walk_rsp_vld = 1; walk_rsp_data = 64'hABC; walk_rsp_flt = 0;
    w0 = wen_cnt;
    tick();
    walk_rsp_vld = 0;
    n_chk++; if (tlb_wen !== 1'b1 || tlb_wdata !== 64'hABC) begin
      n_fail++; $display("FAIL fill_data: wen=%b data=%h exp 1/abc", tlb_wen, tlb_wdata);
    end
    n_chk++; if (tlb_waddr !== a || tlb_wnat !== 1'b1) begin
      n_fail++; $display("FAIL fill_addr: addr=%h nat=%b exp %h/1", tlb_waddr, tlb_wnat, a);
    end
    tick();
    n_chk++; if (tlb_wen !== 1'b0 || fetch_stall !== 1'b0 || (wen_cnt - w0) != 1) begin
      n_fail++; $display("FAIL fill_done: wen=%b stall=%b pulses=%0d exp 0/0/1", tlb_wen, fetch_stall, wen_cnt - w0);
    end
  endtask

  task automatic test_fault;
    int w0;
    w0 = wen_cnt;
    fetch_vld = 1; tlb_hit = 0; fetch_addr = 65'h4000; fetch_nat = 0;
    tick();
    fetch_vld = 0; walk_ack = 1;
    tick();
    walk_ack = 0; walk_rsp_vld = 1; walk_rsp_flt = 1; walk_rsp_data = 64'hDEAD;
    tick();
    walk_rsp_vld = 0; walk_rsp_flt = 0;
    n_chk++; if (fault_vld !== 1'b1 || fault_addr !== 65'h4000) begin
      n_fail++; $display("FAIL fault_pulse: vld=%b addr=%h exp 1/4000", fault_vld, fault_addr);
    end
    n_chk++; if (fetch_stall !== 1'b0 || tlb_wen !== 1'b0) begin
      n_fail++; $display("FAIL fault_state: stall=%b wen=%b exp 0/0", fetch_stall, tlb_wen);
    end
    tick();
    n_chk++; if (fault_vld !== 1'b0 || wen_cnt != w0) begin
      n_fail++; $display("FAIL fault_once: vld=%b wen_pulses=%0d exp 0/0", fault_vld, wen_cnt - w0);
    end
  endtask

  task automatic test_flush_in_wait;
    int n; bit s_ok; bit r_seen; int w0;
    w0 = wen_cnt;
    fetch_vld = 1; tlb_hit = 0; fetch_addr = 65'h8000;
    tick();
    fetch_vld = 0; walk_ack = 1;
    tick();
    walk_ack = 0; flush_req = 1;
    tick();
    flush_req = 0;
    n_chk++; if (flush_busy !== 1'b0 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL pend_wait: busy=%b stall=%b exp 0/1", flush_busy, fetch_stall);
    end
    walk_rsp_vld = 1; walk_rsp_data = 64'h123;
    tick();
    walk_rsp_vld = 0;
    n_chk++; if (tlb_wen !== 1'b1 || tlb_wdata !== 64'h123 || flush_busy !== 1'b0) begin
      n_fail++; $display("FAIL pend_fill: wen=%b data=%h busy=%b exp 1/123/0", tlb_wen, tlb_wdata, flush_busy);
    end
    tick();
    n_chk++; if (flush_busy !== 1'b1 || tlb_waddr !== '0 || (wen_cnt - w0) != 1) begin
      n_fail++; $display("FAIL pend_flush_start: busy=%b addr=%h pulses=%0d exp 1/0/1", flush_busy, tlb_waddr, wen_cnt - w0);
    end
    run_flush(n, s_ok, r_seen);
    n_chk++; if (n != 64 || !s_ok) begin
      n_fail++; $display("FAIL pend_flush_len: cycles=%0d stall_ok=%b exp 64/1", n, s_ok);
    end
    n_chk++; if (fetch_stall !== 1'b0) begin n_fail++; $display("FAIL pend_flush_end: stall=%b exp 0", fetch_stall); end
  endtask

  task automatic test_flush_and_miss;
    int n; bit s_ok; bit r_seen;
    flush_req = 1; fetch_vld = 1; tlb_hit = 0; fetch_addr = 65'hC000;
    tick();
    flush_req = 0; fetch_vld = 0;
    n_chk++; if (flush_busy !== 1'b1 || walk_req !== 1'b0) begin
      n_fail++; $display("FAIL contend_start: busy=%b req=%b exp 1/0", flush_busy, walk_req);
    end
    run_flush(n, s_ok, r_seen);
    n_chk++; if (n != 64 || r_seen) begin
      n_fail++; $display("FAIL contend_flush: cycles=%0d req_seen=%b exp 64/0", n, r_seen);
    end
    n_chk++; if (walk_req !== 1'b0 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL contend_end: req=%b stall=%b exp 0/0", walk_req, fetch_stall);
    end
  endtask

  task automatic test_flush_restart;
    int n; bit s_ok; bit r_seen;
    flush_req = 1;
    tick();
    flush_req = 0;
    repeat (5) tick();
    n_chk++; if (tlb_waddr !== (AW'(5) << 13)) begin
      n_fail++; $display("FAIL restart_mid: addr=%h exp %h", tlb_waddr, AW'(5) << 13);
    end
    flush_req = 1;
    tick();
    flush_req = 0;
    n_chk++; if (tlb_waddr !== '0 || flush_busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_idx: addr=%h busy=%b exp 0/1", tlb_waddr, flush_busy);
    end
    run_flush(n, s_ok, r_seen);
    n_chk++; if (n != 64) begin n_fail++; $display("FAIL restart_len: cycles=%0d exp 64", n); end
  endtask

  task automatic test_reset_abort;
    int n; bit s_ok; bit r_seen;
    fetch_vld = 1; tlb_hit = 0; fetch_addr = 65'h1_0000;
    tick();
    fetch_vld = 0;
    n_chk++; if (walk_req !== 1'b1) begin n_fail++; $display("FAIL abort_req: got %b exp 1", walk_req); end
    rst = 1;
    tick();
    rst = 0;
    n_chk++; if (walk_req !== 1'b0 || flush_busy !== 1'b1 || fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL abort_rst: req=%b busy=%b stall=%b exp 0/1/1", walk_req, flush_busy, fetch_stall);
    end
    run_flush(n, s_ok, r_seen);
    n_chk++; if (n != 64 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL abort_flush: cycles=%0d stall=%b exp 64/0", n, fetch_stall);
    end
  endtask

`ifdef CTLB_MISS_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n; int w0;
    w0 = wen_cnt;
    fetch_vld = 1; tlb_hit = 0; fetch_addr = 65'h2_0000;
    tick();
    fetch_vld = 0;
    n = 0;
    while (fault_vld !== 1'b1 && n < 400) begin tick(); n++; end
    n_chk++; if (n != 255 || fault_addr !== 65'h2_0000) begin
      n_fail++; $display("FAIL tmo_fault: cycles=%0d addr=%h exp 255/20000", n, fault_addr);
    end
    n_chk++; if (walk_req !== 1'b0 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: req=%b stall=%b exp 0/0", walk_req, fetch_stall);
    end
    walk_rsp_vld = 1; walk_rsp_data = 64'hBAD;
    tick();
    walk_rsp_vld = 0;
    tick();
    n_chk++; if (wen_cnt != w0) begin n_fail++; $display("FAIL tmo_late_rsp: wen_pulses=%0d exp 0", wen_cnt - w0); end
  endtask
`endif

  initial begin
    test_reset();
    test_miss_fill();
    test_fault();
    test_flush_in_wait();
    test_flush_and_miss();
    test_flush_restart();
    test_reset_abort();
`ifdef CTLB_MISS_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
